// File: rtl/iterative_mdu.sv
// iterative_mdu: radix-2 multi-cycle multiply/divide unit with HI/LO registers.
// Handles MULT/MULTU/DIV/DIVU (iterative, one bit per cycle) and MTHI/MTLO.
// Optional macro MDU_FAST_MULT_EN: multiplies use a single-cycle multiplier
// (IDLE -> FIX -> IDLE); divides stay iterative.
module iterative_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // MUL: {partial product, multiplier}; DIV: low half = dividend/quotient
    logic [WIDTH-1:0]   rem_q, rem_d;      // DIV partial remainder (always < divisor, so WIDTH bits suffice)
    logic [WIDTH-1:0]   b_q, b_d;          // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;  // dividend as issued, returned on divide by zero
    logic               neg_q, neg_d;      // product/quotient must be negated
    logic               rneg_q, rneg_d;    // remainder must be negated
    logic               is_div_q, is_div_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               op_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_trial;
`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
`endif

    // Operand magnitudes and one iteration of each datapath
    always_comb begin
        op_signed = ~op[2] & ~op[0];
        abs_a     = (op_signed && operandA[WIDTH-1]) ? -operandA : operandA;
        abs_b     = (op_signed && operandB[WIDTH-1]) ? -operandB : operandB;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_q};
`ifdef MDU_FAST_MULT_EN
        fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif
    end

    // Next-state logic for the control FSM and datapath registers
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        b_d      = b_q;
        a_raw_d  = a_raw_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        is_div_d = is_div_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001: begin
                            b_d      = abs_a;
                            neg_d    = op_signed & (operandA[WIDTH-1] ^ operandB[WIDTH-1]);
                            rneg_d   = 1'b0;
                            is_div_d = 1'b0;
                            busy_d   = 1'b1;
`ifdef MDU_FAST_MULT_EN
                            acc_d    = fast_prod;
                            state_d  = S_FIX;
`else
                            acc_d    = {{WIDTH{1'b0}}, abs_b};
                            cnt_d    = CW'(WIDTH-1);
                            state_d  = S_MUL;
`endif
                        end
                        3'b010, 3'b011: begin
                            acc_d    = {{WIDTH{1'b0}}, abs_a};
                            rem_d    = '0;
                            b_d      = abs_b;
                            a_raw_d  = operandA;
                            neg_d    = op_signed & (operandA[WIDTH-1] ^ operandB[WIDTH-1]);
                            rneg_d   = op_signed & operandA[WIDTH-1];
                            is_div_d = 1'b1;
                            cnt_d    = CW'(WIDTH-1);
                            busy_d   = 1'b1;
                            state_d  = S_DIV;
                        end
                        3'b100: begin
                            hi_d   = operandA;
                            done_d = 1'b1;
                        end
                        3'b101: begin
                            lo_d   = operandA;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_DIV: begin
                // Restoring step: keep the trial difference only if it did not go negative
                rem_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
                acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (b_q == '0) begin
                        lo_d  = '1;
                        hi_d  = a_raw_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = rneg_q ? -rem_q : rem_q;
                    end
                end else begin
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A squash wins over everything, including a same-cycle start or result write
        if (flush) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            b_q      <= '0;
            a_raw_q  <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            b_q      <= b_d;
            a_raw_q  <= a_raw_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign divByZero = dbz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_iterative_mdu.sv
// Testbench for iterative_mdu: directed cases with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_iterative_mdu;

    localparam int W = 32;
`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int DIV_LAT = W + 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, dbz;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad = 0;

    iterative_mdu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operandA(a), .operandB(b), .flush(flush),
        .busy(busy), .done(done), .divByZero(dbz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from the arithmetic rules
    function automatic void calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] rh, output logic [W-1:0] rl, output logic z);
        longint     p;
        logic [63:0] u;
        z  = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            3'd0: begin p = longint'($signed(x)) * longint'($signed(y)); {rh, rl} = p; end
            3'd1: begin u = {32'b0, x} * {32'b0, y}; {rh, rl} = u; end
            3'd2, 3'd3: begin
                if (y == 0) begin
                    rl = '1; rh = x; z = 1'b1;
                end else if (o == 3'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000; rh = '0;
                end else if (o == 3'd2) begin
                    rl = $signed(x) / $signed(y);
                    rh = $signed(x) % $signed(y);
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
            default: ;
        endcase
    endfunction

    // Transaction-level model: pending op with remaining edge count
    logic         m_busy = 0, m_done = 0, m_dbz = 0, m_pend = 0, p_dbz = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_rem = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_done = 0; m_dbz = 0; m_pend = 0; m_hi = '0; m_lo = '0; m_rem = 0;
        end else begin
            m_done = 0;
            m_dbz  = 0;
            if (m_pend) begin
                if (flush) begin
                    m_pend = 0; m_busy = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_pend = 0; m_busy = 0; m_done = 1;
                        m_dbz = p_dbz; m_hi = p_hi; m_lo = p_lo;
                    end
                end
            end else if (start && !flush) begin
                if (op <= 3'd3) begin
                    calc(op, a, b, p_hi, p_lo, p_dbz);
                    m_pend = 1; m_busy = 1;
                    m_rem = ((op <= 3'd1) ? MUL_LAT : DIV_LAT) - 1;
                end else if (op == 3'd4) begin
                    m_hi = a; m_done = 1;
                end else if (op == 3'd5) begin
                    m_lo = a; m_done = 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (reset) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("divByZero", dbz, m_dbz);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    // Issue one op and count negedges until done (done after edge N -> lat N)
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output logic z);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; flush = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 100);
        z = dbz;
        $display("op=%0d A=%h B=%h -> hi=%h lo=%h dbz=%0b lat=%0d", o, x, y, hi, lo, z, lat);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom % 6)
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom % 16);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int          lat;
        logic        z;
        logic [W-1:0] th, tl;
        logic        tz;

        // Model pinned against hand-computed values
        calc(3'd2, 32'hFFFF_FFF9, 32'd2, th, tl, tz);
        chk("model_div_neg", {th, tl}, 64'hFFFF_FFFF_FFFF_FFFD);
        calc(3'd0, 32'hFFFF_FFFD, 32'd5, th, tl, tz);
        chk("model_mult_neg", {th, tl}, 64'hFFFF_FFFF_FFFF_FFF1);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, lat, z);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        chk("multu_lat", lat, MUL_LAT);

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, lat, z);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, z);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lat", lat, DIV_LAT);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, z);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0);
        chk("divovf_dbz", z, 1'b0);

        run_op(3'd3, 32'd10, 32'd0, lat, z);
        chk("dbz_lo", lo, 32'hFFFF_FFFF);
        chk("dbz_hi", hi, 32'h0000_000A);
        chk("dbz_flag", z, 1'b1);

        run_op(3'd4, 32'h1234_5678, 32'd0, lat, z);
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lat", lat, 1);
        run_op(3'd5, 32'h9ABC_DEF0, 32'd0, lat, z);
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);

        // Flush mid-multiply; a second start while busy must be ignored
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'hDEAD_BEEF; b = 32'h77;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start = (n == 5);
            op    = (n == 5) ? 3'd3 : 3'd1;
            flush = (n == 10);
        end
        chk("flush_busy", busy, 1'b0);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            chk("flush_nodone", done, 1'b0);
        end
        chk("flush_hi", hi, 32'h1234_5678);
        chk("flush_lo", lo, 32'h9ABC_DEF0);
        $display("flush test: busy=%0b hi=%h lo=%h", busy, hi, lo);

        // Async reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_dbz", dbz, 1'b0);
        chk("mrst_hi", hi, 32'h0);
        chk("mrst_lo", lo, 32'h0);
        $display("reset mid-div: busy=%0b hi=%h lo=%h", busy, hi, lo);
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start = (($urandom % 3) == 0);
            op    = 3'($urandom % 8);
            a     = rnd_operand();
            b     = rnd_operand();
            flush = (($urandom % 150) == 0);
            if (done)
                $display("random done: hi=%h lo=%h dbz=%0b", hi, lo, dbz);
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        repeat (W + 6) @(negedge clk);
        chk("drain_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
